// File: rtl/rc_axi_pkg.sv
// Shared definitions for the RC AXI4-Lite register slave: register byte
// offsets, response codes and the write/read FSM state types.
package rc_axi_pkg;

   localparam logic [4:0] OFS_REG0 = 5'h00;
   localparam logic [4:0] OFS_REG1 = 5'h04;
   localparam logic [4:0] OFS_REG2 = 5'h08;
   localparam logic [4:0] OFS_REG3 = 5'h0C;
   localparam logic [4:0] OFS_TS   = 5'h10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_HAVE_A = 2'd1,
      W_HAVE_D = 2'd2,
      W_RESP   = 2'd3
   } w_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_e;

   // Word index (addr[4:2]) refers to one of the four read/write registers.
   function automatic logic is_rw_word(input logic [2:0] word);
      return {word, 2'b00} < OFS_TS;
   endfunction

endpackage

// File: rtl/rc_axi_lite_slave_if.sv
// AXI4-Lite bus bundle between a master and the RC register slave.
interface rc_axi_lite_slave_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic [2:0]              S_AXI_AWPROT;
   logic                    S_AXI_AWVALID;
   logic                    S_AXI_AWREADY;
   logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                    S_AXI_WVALID;
   logic                    S_AXI_WREADY;
   logic [1:0]              S_AXI_BRESP;
   logic                    S_AXI_BVALID;
   logic                    S_AXI_BREADY;
   logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [2:0]              S_AXI_ARPROT;
   logic                    S_AXI_ARVALID;
   logic                    S_AXI_ARREADY;
   logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]              S_AXI_RRESP;
   logic                    S_AXI_RVALID;
   logic                    S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      output S_AXI_RREADY
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      input  S_AXI_RREADY
   );

endinterface

// File: rtl/rc_axi_wstrb_merge.sv
// Byte-strobe merge: each byte lane takes the new word where its strobe is
// set and keeps the old word otherwise.
module rc_axi_wstrb_merge (
   input  logic [31:0] old_word,
   input  logic [31:0] new_word,
   input  logic [3:0]  wstrb,
   output logic [31:0] merged
);

   // Per-lane select between old and new bytes.
   always_comb begin
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (wstrb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
   end

endmodule

// File: rtl/rc_axi_lite_slave.sv
// AXI4-Lite slave with four RW registers for the RC channel logic.
// Optional feature macro: RC_AXI_TIMESTAMP_EN adds a free-running 32-bit
// timestamp readable at offset 0x10; without it 0x10 is unmapped.
//
// Write FSM
//   state    | meaning
//   W_IDLE   | accepting AW and W
//   W_HAVE_A | address held, waiting for data
//   W_HAVE_D | data held, waiting for address
//   W_RESP   | BVALID up, waiting for BREADY
// Read FSM
//   state    | meaning
//   R_IDLE   | accepting AR
//   R_DATA   | RVALID up, waiting for RREADY
module rc_axi_lite_slave
   import rc_axi_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   rc_axi_lite_slave_if.slave              s_axi,
   output logic [4*C_S_AXI_DATA_WIDTH-1:0] REG_OUT
);

   localparam int DW = C_S_AXI_DATA_WIDTH;

   logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
   logic [2:0]    aw_word, ar_word;
   logic          aw_hs, w_hs, ar_hs, commit;

   w_state_e      w_state_q, w_state_d;
   logic          awready_q, awready_d;
   logic          wready_q, wready_d;
   logic          bvalid_q, bvalid_d;
   logic [1:0]    bresp_q, bresp_d;
   logic [2:0]    awword_q, awword_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [3:0]    wstrb_q, wstrb_d;
   logic [DW-1:0] regs_q [4];
   logic [DW-1:0] regs_d [4];

   logic [2:0]    cm_word;
   logic [DW-1:0] cm_data, merged;
   logic [3:0]    cm_strb;

   r_state_e      r_state_q, r_state_d;
   logic          arready_q, arready_d;
   logic          rvalid_q, rvalid_d;
   logic [1:0]    rresp_q, rresp_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [DW-1:0] rd_data;
   logic [1:0]    rd_resp;

`ifdef RC_AXI_TIMESTAMP_EN
   logic [31:0]   ts_q, ts_d;
`endif

   logic          unused_bits;

   assign awaddr  = s_axi.S_AXI_AWADDR;
   assign araddr  = s_axi.S_AXI_ARADDR;
   assign aw_word = awaddr[4:2];
   assign ar_word = araddr[4:2];
   assign unused_bits = ^{awaddr[1:0], araddr[1:0], s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

   assign aw_hs = s_axi.S_AXI_AWVALID & awready_q;
   assign w_hs  = s_axi.S_AXI_WVALID & wready_q;
   assign ar_hs = s_axi.S_AXI_ARVALID & arready_q;

   // Commit fires on the edge where address and data are both available.
   assign commit = ((w_state_q == W_IDLE) & aw_hs & w_hs)
                 | ((w_state_q == W_HAVE_A) & w_hs)
                 | ((w_state_q == W_HAVE_D) & aw_hs);

   // Pick held or live address/data for the commit.
   always_comb begin
      cm_word = awword_q;
      cm_data = wdata_q;
      cm_strb = wstrb_q;
      if ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_D)) cm_word = aw_word;
      if ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_A)) begin
         cm_data = s_axi.S_AXI_WDATA;
         cm_strb = s_axi.S_AXI_WSTRB;
      end
   end

   rc_axi_wstrb_merge u_merge (
      .old_word (regs_q[cm_word[1:0]]),
      .new_word (cm_data),
      .wstrb    (cm_strb),
      .merged   (merged)
   );

   // Write FSM next state, register update and response.
   always_comb begin
      w_state_d = w_state_q;
      awword_d  = awword_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      regs_d    = regs_q;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               w_state_d = W_RESP;
            end else if (aw_hs) begin
               w_state_d = W_HAVE_A;
               awword_d  = aw_word;
            end else if (w_hs) begin
               w_state_d = W_HAVE_D;
               wdata_d   = s_axi.S_AXI_WDATA;
               wstrb_d   = s_axi.S_AXI_WSTRB;
            end
         end
         W_HAVE_A: if (w_hs) w_state_d = W_RESP;
         W_HAVE_D: if (aw_hs) w_state_d = W_RESP;
         W_RESP: begin
            if (s_axi.S_AXI_BREADY) begin
               w_state_d = W_IDLE;
               bvalid_d  = 1'b0;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
      if (commit) begin
         bvalid_d = 1'b1;
         if (is_rw_word(cm_word)) begin
            regs_d[cm_word[1:0]] = merged;
            bresp_d = RESP_OKAY;
         end else begin
            bresp_d = RESP_SLVERR;
         end
      end
      awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_D);
      wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_A);
   end

   // Read mux; sees registers before any same-edge write commit.
   always_comb begin
      rd_data = '0;
      rd_resp = RESP_SLVERR;
      case ({ar_word, 2'b00})
         OFS_REG0: begin rd_data = regs_q[0]; rd_resp = RESP_OKAY; end
         OFS_REG1: begin rd_data = regs_q[1]; rd_resp = RESP_OKAY; end
         OFS_REG2: begin rd_data = regs_q[2]; rd_resp = RESP_OKAY; end
         OFS_REG3: begin rd_data = regs_q[3]; rd_resp = RESP_OKAY; end
`ifdef RC_AXI_TIMESTAMP_EN
         OFS_TS:   begin rd_data = ts_q;      rd_resp = RESP_OKAY; end
`endif
         default: begin
            rd_data = '0;
            rd_resp = RESP_SLVERR;
         end
      endcase
   end

   // Read FSM next state and data capture.
   always_comb begin
      r_state_d = r_state_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               r_state_d = R_DATA;
               rvalid_d  = 1'b1;
               rdata_d   = rd_data;
               rresp_d   = rd_resp;
            end
         end
         R_DATA: begin
            if (s_axi.S_AXI_RREADY) begin
               r_state_d = R_IDLE;
               rvalid_d  = 1'b0;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      arready_d = (r_state_d == R_IDLE);
   end

   // Write-side state and register file.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         awword_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      end else begin
         w_state_q <= w_state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         awword_q  <= awword_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
      end
   end

   // Read-side state and registered read data.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
      end
   end

`ifdef RC_AXI_TIMESTAMP_EN
   assign ts_d = ts_q + 32'd1;

   // Free-running timestamp, wraps naturally.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) ts_q <= '0;
      else        ts_q <= ts_d;
   end
`endif

   assign s_axi.S_AXI_AWREADY = awready_q;
   assign s_axi.S_AXI_WREADY  = wready_q;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = bresp_q;
   assign s_axi.S_AXI_ARREADY = arready_q;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RRESP   = rresp_q;
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign REG_OUT = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};

endmodule
